// File: rtl/roic_lvds_tx_serializer_pkg.sv
// roic_tx_pkg: shared state type and default word patterns for the ROIC LVDS transmit serializer.
package roic_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        SHIFT
    } tx_state_e;

    localparam logic [15:0] TRAIN_PATTERN_DEF = 16'hF0F0;
    localparam logic [15:0] IDLE_PATTERN_DEF  = 16'hA5A5;

endpackage

// File: rtl/roic_lvds_tx_serializer_if.sv
// roic_lvds_tx_serializer_if: parallel word valid/ready handshake feeding the serializer.
interface roic_lvds_tx_serializer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/roic_lvds_tx_serializer_clkdiv.sv
// roic_tx_clkdiv: free-running clk_in / DIV_RATIO divider; output is the counter MSB (50% duty).
module roic_tx_clkdiv #(
    parameter int DIV_RATIO = 4
) (
    input  logic clk_in,
    input  logic clk_reset_n,
    output logic clk_div_out
);
    localparam int DW = $clog2(DIV_RATIO);

    logic [DW-1:0] div_cnt_q, div_cnt_d;

    always_comb div_cnt_d = div_cnt_q + DW'(1);

    always_ff @(posedge clk_in or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign clk_div_out = div_cnt_q[DW-1];
endmodule

// File: rtl/roic_lvds_tx_serializer.sv
// roic_lvds_tx_serializer: ROIC emulator emitting serial data, frame clock and divided clock.
// Optional ramp test-pattern source is built when ROIC_TX_RAMP_PATTERN_EN is defined.
module roic_lvds_tx_serializer
    import roic_tx_pkg::*;
#(
    parameter int                    WORD_WIDTH    = 16,
    parameter int                    DIV_RATIO     = 4,
    parameter int                    TRAIN_WORDS   = 8,
    parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = WORD_WIDTH'(TRAIN_PATTERN_DEF),
    parameter logic [WORD_WIDTH-1:0] IDLE_PATTERN  = WORD_WIDTH'(IDLE_PATTERN_DEF)
) (
    input  logic                     clk_in,
    input  logic                     clk_reset_n,
    input  logic                     tx_enable,
    roic_lvds_tx_serializer_if.slave word_if,
`ifdef ROIC_TX_RAMP_PATTERN_EN
    input  logic                     ramp_mode,
`endif
    input  logic                     clear_underflow,
    output logic                     sdata_out,
    output logic                     fclk_out,
    output logic                     clk_div_out,
    output logic                     train_active,
    output logic                     underflow
);
    localparam int             CW          = $clog2(WORD_WIDTH);
    localparam int             TW          = $clog2(TRAIN_WORDS) + 1;
    localparam logic [CW-1:0]  LAST_BIT    = CW'(WORD_WIDTH - 1);
    localparam logic [CW-1:0]  PRELAST_BIT = CW'(WORD_WIDTH - 2);
    localparam logic [CW-1:0]  HALF_BIT    = CW'(WORD_WIDTH / 2);
    localparam logic [TW-1:0]  LAST_TRAIN  = TW'(TRAIN_WORDS - 1);

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         train_cnt_q, train_cnt_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic                  sdata_q, sdata_d;
    logic                  fclk_q, fclk_d;
    logic                  ready_q, ready_d;
    logic                  train_q, train_d;
    logic                  uflow_q, uflow_d;
    logic                  cont_q, cont_d;
    logic                  last_train;
    logic                  load_en;
    logic [WORD_WIDTH-1:0] load_word;
`ifdef ROIC_TX_RAMP_PATTERN_EN
    logic                  ramp_sel_q, ramp_sel_d;
    logic [WORD_WIDTH-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [WORD_WIDTH-1:0] ramp_base;
`endif

    roic_tx_clkdiv #(.DIV_RATIO(DIV_RATIO)) u_clkdiv (
        .clk_in      (clk_in),
        .clk_reset_n (clk_reset_n),
        .clk_div_out (clk_div_out)
    );

    assign last_train = (train_cnt_q == LAST_TRAIN);

    // Continue/stop and ready are decided one bit early so word_ready can be a registered output.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        train_cnt_d = train_cnt_q;
        shreg_d     = {shreg_q[WORD_WIDTH-2:0], 1'b0};
        sdata_d     = shreg_q[WORD_WIDTH-1];
        cont_d      = cont_q;
        ready_d     = 1'b0;
        uflow_d     = uflow_q & ~clear_underflow;
        load_en     = 1'b0;
        load_word   = TRAIN_PATTERN;
`ifdef ROIC_TX_RAMP_PATTERN_EN
        ramp_sel_d  = ramp_sel_q;
        ramp_cnt_d  = ramp_cnt_q;
        ramp_base   = (state_q == TRAIN) ? '0 : ramp_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                bit_cnt_d   = '0;
                train_cnt_d = '0;
                if (tx_enable) begin
                    state_d = TRAIN;
                    load_en = 1'b1;
                end
            end
            default: begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == PRELAST_BIT) begin
                    cont_d  = tx_enable;
                    ready_d = tx_enable && ((state_q == SHIFT) || last_train);
`ifdef ROIC_TX_RAMP_PATTERN_EN
                    ramp_sel_d = ramp_mode;
                    ready_d    = ready_d && !ramp_mode;
`endif
                end
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (!cont_q) begin
                        state_d = IDLE;
                    end else if ((state_q == TRAIN) && !last_train) begin
                        train_cnt_d = train_cnt_q + TW'(1);
                        load_en     = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        load_en = 1'b1;
`ifdef ROIC_TX_RAMP_PATTERN_EN
                        if (state_q == TRAIN) ramp_cnt_d = '0;
                        if (ramp_sel_q) begin
                            load_word  = ramp_base;
                            ramp_cnt_d = ramp_base + WORD_WIDTH'(1);
                        end else
`endif
                        if (word_if.word_valid) begin
                            load_word = word_if.word_data;
                        end else begin
                            load_word = IDLE_PATTERN;
                            uflow_d   = 1'b1;
                        end
                    end
                end
            end
        endcase
        if (load_en) begin
            sdata_d = load_word[WORD_WIDTH-1];
            shreg_d = {load_word[WORD_WIDTH-2:0], 1'b0};
        end
        if (state_d == IDLE) sdata_d = 1'b0;
        fclk_d  = (state_d != IDLE) && (bit_cnt_d < HALF_BIT);
        train_d = (state_d == TRAIN);
    end

    always_ff @(posedge clk_in or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            train_cnt_q <= '0;
            shreg_q     <= '0;
            sdata_q     <= 1'b0;
            fclk_q      <= 1'b0;
            ready_q     <= 1'b0;
            train_q     <= 1'b0;
            uflow_q     <= 1'b0;
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            shreg_q     <= shreg_d;
            sdata_q     <= sdata_d;
            fclk_q      <= fclk_d;
            ready_q     <= ready_d;
            train_q     <= train_d;
            uflow_q     <= uflow_d;
            cont_q      <= cont_d;
        end
    end

`ifdef ROIC_TX_RAMP_PATTERN_EN
    always_ff @(posedge clk_in or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            ramp_sel_q <= 1'b0;
            ramp_cnt_q <= '0;
        end else begin
            ramp_sel_q <= ramp_sel_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end
`endif

    assign word_if.word_ready = ready_q;
    assign sdata_out          = sdata_q;
    assign fclk_out           = fclk_q;
    assign train_active       = train_q;
    assign underflow          = uflow_q;
endmodule

// File: tb/tb_roic_lvds_tx_serializer.sv
// tb_roic_lvds_tx_serializer: directed, table-driven check of the ROIC LVDS transmit serializer.
// Define ROIC_TX_RAMP_PATTERN_EN to also exercise the ramp pattern source.
`timescale 1ns/1ps
module tb_roic_lvds_tx_serializer;
    localparam int          WW      = 16;
    localparam logic [15:0] TRAIN_W = 16'hF0F0;
    localparam logic [15:0] IDLE_W  = 16'hA5A5;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        clr;
        logic [15:0] exp_word;
        logic        exp_uf;
    } vec_t;

    logic clk_in          = 1'b0;
    logic clk_reset_n     = 1'b0;
    logic tx_enable       = 1'b0;
    logic clear_underflow = 1'b0;
    logic sdata_out, fclk_out, clk_div_out, train_active, underflow;
`ifdef ROIC_TX_RAMP_PATTERN_EN
    logic ramp_mode = 1'b0;
`endif
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;
    vec_t vecs [8];

    roic_lvds_tx_serializer_if #(.WORD_WIDTH(WW)) wif ();

    roic_lvds_tx_serializer #(
        .WORD_WIDTH    (WW),
        .DIV_RATIO     (4),
        .TRAIN_WORDS   (8),
        .TRAIN_PATTERN (16'hF0F0),
        .IDLE_PATTERN  (16'hA5A5)
    ) dut (
        .clk_in          (clk_in),
        .clk_reset_n     (clk_reset_n),
        .tx_enable       (tx_enable),
        .word_if         (wif),
`ifdef ROIC_TX_RAMP_PATTERN_EN
        .ramp_mode       (ramp_mode),
`endif
        .clear_underflow (clear_underflow),
        .sdata_out       (sdata_out),
        .fclk_out        (fclk_out),
        .clk_div_out     (clk_div_out),
        .train_active    (train_active),
        .underflow       (underflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        edges++;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic c);
        wif.word_valid  = v;
        wif.word_data   = d;
        clear_underflow = c;
    endtask

    // One wire cycle showing bit i (MSB first) of word w.
    task automatic chk_bit(input string tag, input int i, input logic [15:0] w,
                           input logic exp_train, input logic exp_ready, input logic exp_uf);
        chk({tag, " sdata"}, 16'(sdata_out), 16'(w[15 - i]));
        chk({tag, " fclk"}, 16'(fclk_out), 16'(i < 8));
        chk({tag, " train"}, 16'(train_active), 16'(exp_train));
        chk({tag, " ready"}, 16'(wif.word_ready), 16'(exp_ready));
        chk({tag, " uflow"}, 16'(underflow), 16'(exp_uf));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " sdata"}, 16'(sdata_out), 16'h0);
        chk({tag, " fclk"}, 16'(fclk_out), 16'h0);
        chk({tag, " train"}, 16'(train_active), 16'h0);
        chk({tag, " ready"}, 16'(wif.word_ready), 16'h0);
    endtask

    task automatic train_run(input logic exp_ready_end, input logic nv, input logic [15:0] nd);
        for (int i = 0; i < 128; i++) begin
            chk_bit("train", i % 16, TRAIN_W, 1'b1, (i == 127) && exp_ready_end, 1'b0);
            if (i == 127) drive(nv, nd, 1'b0);
            if (i % 16 == 15) $display("training word %0d sent", i / 16);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, IDLE_W,   1'b1};
        vecs[3] = '{1'b1, 16'h0F0F, 1'b0, 16'h0F0F, 1'b1};
        vecs[4] = '{1'b1, 16'h8001, 1'b1, 16'h8001, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, IDLE_W,   1'b1};
        vecs[6] = '{1'b1, 16'h5A5A, 1'b0, 16'h5A5A, 1'b1};
        vecs[7] = '{1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
        drive(1'b0, 16'h0000, 1'b0);

        repeat (3) @(posedge clk_in);
        #1;
        chk_quiet("reset");
        chk("reset uflow", 16'(underflow), 16'h0);
        chk("reset div", 16'(clk_div_out), 16'h0);
        $display("reset state checked");

        clk_reset_n = 1'b1;
        edges       = 0;
        for (int c = 0; c <= 20; c++) begin
            chk("idle div", 16'(clk_div_out), 16'((edges % 4) >= 2));
            chk_quiet("idle");
            if (c < 20) tick();
        end
        $display("idle divider run checked");

        tx_enable = 1'b1;
        tick();
        train_run(1'b1, vecs[0].valid, vecs[0].data);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 0) clear_underflow = 1'b0;
                chk_bit("word", i, vecs[k].exp_word, 1'b0, i == 15, vecs[k].exp_uf);
                if (i == 15) begin
                    if (k < 7) drive(vecs[k + 1].valid, vecs[k + 1].data, vecs[k + 1].clr);
                    else       drive(1'b1, 16'hC3C3, 1'b0);
                end
                tick();
            end
            $display("word %0d: sent %h underflow %b", k, vecs[k].exp_word, vecs[k].exp_uf);
        end

        for (int i = 0; i < 16; i++) begin
            if (i == 5) tx_enable = 1'b0;
            chk_bit("abort", i, 16'hC3C3, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            chk_quiet("post-abort");
            tick();
        end
        $display("shift abort: c3c3 completed then idle");

        tx_enable = 1'b1;
        tick();
        train_run(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            chk_bit("pre-reset", i, IDLE_W, 1'b0, 1'b0, 1'b1);
            if (i < 9) tick();
        end
        clk_reset_n = 1'b0;
        #1;
        chk_quiet("mid-reset");
        chk("mid-reset uflow", 16'(underflow), 16'h0);
        chk("mid-reset div", 16'(clk_div_out), 16'h0);
        $display("reset at bit 9 checked");
        repeat (2) @(posedge clk_in);
        #1;
        clk_reset_n = 1'b1;
        edges       = 0;

        drive(1'b0, 16'h0000, 1'b0);
        tx_enable = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            if (i == 20) tx_enable = 1'b0;
            chk_bit("train-abort", i % 16, TRAIN_W, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            chk_quiet("train-abort idle");
            tick();
        end
        $display("training abort after word 1 checked");

`ifdef ROIC_TX_RAMP_PATTERN_EN
        ramp_mode = 1'b1;
        tx_enable = 1'b1;
        tick();
        train_run(1'b0, 1'b0, 16'h0000);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) begin
                chk_bit("ramp", i, 16'(w), 1'b0, 1'b0, 1'b0);
                tick();
            end
            $display("ramp word %0d sent", w);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
